tape_prefetch: RTL

TAPE_PREFETCH -- requirements
Module: tape_prefetch

---
 rtl/tape_pkg.sv | 13 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/tape_prefetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared constants and FSM state type for the tape prefetcher
package tape_pkg;

    // Byte address width of the SDRAM tape image.
    localparam int ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WIN,
        FETCH
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous byte FIFO with flush, head byte presented combinationally
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           synchronous clear (same effect as reset on contents)
//   push, push_data write one entry; never asserted when full
//   pop             remove head entry; never asserted when empty
//   pop_data        head entry, zero while empty
//   empty, full     occupancy flags
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Pointers wrap naturally because DEPTH is a power of two; count is one
    // bit wider so it can represent DEPTH itself.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    // Stale storage is hidden so the head reads zero after reset or flush.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tape_prefetch.sv
// rtl/tape_prefetch.sv - prefetches a tape image from SDRAM into a byte FIFO during CPU refresh windows
// Ports:
//   clk, reset          28 MHz system clock, synchronous active-high reset
//   start, size         one-cycle restart pulse and image length sampled with it
//   rfsh_n              CPU refresh strobe, low marks a free memory window
//   mem_addr, mem_rd    SDRAM byte address and read request of the current fetch
//   mem_dout            SDRAM read data, sampled on the last fetch cycle
//   out_data, out_valid, out_ready   byte stream to the consumer
//   eof                 whole image fetched and consumed
module tape_prefetch
    import tape_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ACK_DELAY = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] size,
    input  logic              rfsh_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              eof
);

    localparam logic [3:0]        LAST_BEAT = 4'(ACK_DELAY - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] size_r;
    logic [3:0]        beat;
    logic              rfsh_q;
    logic              rfsh_prev;
    logic              win_open;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    // A window opens on the falling edge of the registered refresh strobe.
    assign win_open = !rfsh_q && rfsh_prev;

    // A restart in the same cycle discards the completing byte via the flush.
    assign push = (state == FETCH) && (beat == LAST_BEAT) && !start;
    assign pop  = out_valid && out_ready;

    assign out_valid = !fifo_empty;
    assign eof       = (state != IDLE) && (fetch_addr == size_r) && fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            size_r     <= '0;
            beat       <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            rfsh_q     <= 1'b1;
            rfsh_prev  <= 1'b1;
        end else begin
            rfsh_q    <= rfsh_n;
            rfsh_prev <= rfsh_q;
            if (start) begin
                state      <= WAIT_WIN;
                fetch_addr <= '0;
                size_r     <= size;
                beat       <= '0;
                mem_rd     <= 1'b0;
                mem_addr   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    WAIT_WIN: begin
                        // A free FIFO slot at issue stays free: only pops
                        // can change the count while the fetch is in flight.
                        if (win_open && (fetch_addr < size_r) && !fifo_full) begin
                            state    <= FETCH;
                            mem_rd   <= 1'b1;
                            mem_addr <= fetch_addr;
                            beat     <= '0;
                        end
                    end
                    FETCH: begin
                        if (beat == LAST_BEAT) begin
                            fetch_addr <= fetch_addr + ADDR_ONE;
                            mem_rd     <= 1'b0;
                            state      <= WAIT_WIN;
                        end else if (rfsh_q) begin
                            // CPU reclaimed the bus early; retry this address
                            // in the next window.
                            mem_rd <= 1'b0;
                            state  <= WAIT_WIN;
                        end else begin
                            beat <= beat + 4'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                    end
                endcase
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (start),
        .push      (push),
        .push_data (mem_dout),
        .pop       (pop),
        .pop_data  (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
